// File: rtl/pmips_mem_arbiter.sv
// pmips_mem_arbiter: shares one single-ported synchronous memory between instruction fetch and
// MEM-stage data access, data first, stalling the pipeline until every requested access is done.
module pmips_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic [1:0]    grant
);
  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;
  localparam logic [2:0] LAT = 3'(RD_LAT);
  state_t r_state, w_next;
  logic [2:0] r_cnt;
  logic r_i_hold, r_d_hold;
  logic w_ipend, w_dpend, w_rd, w_cap, w_start;
  assign w_ipend = i_req & ~r_i_hold & ~i_valid;
  assign w_dpend = (d_read | d_write) & ~r_d_hold & ~d_done;
  assign stall   = w_ipend | w_dpend;
  assign grant   = r_state;
  assign w_rd    = (r_state == I_RD) || (r_state == D_RD);
  // data sits on mem_rdata RD_LAT cycles after the strobe cycle, where the counter started at 0
  assign w_cap   = w_rd && (r_cnt == LAT);
  assign w_start = (r_state == IDLE) && (w_next != IDLE);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = w_dpend ? (d_write ? D_WR : D_RD) : (w_ipend ? I_RD : IDLE);
    else if (r_state == D_WR || w_cap)
      w_next = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_i_hold  <= 1'b0;
      r_d_hold  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_valid   <= 1'b0;
      d_done    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_rd ? r_cnt + 3'd1 : 3'd0;
      r_i_hold <= stall ? (r_i_hold | i_valid) : 1'b0;
      r_d_hold <= stall ? (r_d_hold | d_done) : 1'b0;
      mem_re   <= w_start && (w_next != D_WR);
      mem_we   <= w_start && (w_next == D_WR);
      i_valid  <= w_cap && (r_state == I_RD);
      d_done   <= (w_cap && (r_state == D_RD)) || (r_state == D_WR);
      if (w_start) mem_addr <= w_dpend ? d_addr : i_addr;
      if (w_start && w_next == D_WR) mem_wdata <= d_wdata;
      if (w_cap && r_state == I_RD) i_rdata <= mem_rdata;
      if (w_cap && r_state == D_RD) d_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_pmips_mem_arbiter.sv
// tb_pmips_mem_arbiter: directed scenarios plus randomized pipeline cycles checked against
// an access-count/latency model and a reference copy of memory contents.
module tb_pmips_mem_arbiter;
  logic clock = 0, reset = 0;
  logic i_req = 0, d_read = 0, d_write = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic i_valid, d_done, mem_re, mem_we, stall;
  logic [1:0] grant;
  logic [15:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic i_valid3, d_done3, mem_re3, mem_we3, stall3;
  logic [1:0] grant3;
  logic [15:0] sim_mem1 [256];
  logic [15:0] sim_mem3 [256];
  logic [15:0] ref_mem [256];
  logic [2:0] m1_cnt = 0, m3_cnt = 0;
  logic [7:0] m1_a = 0, m3_a = 0;
  int checks = 0, failures = 0;
  logic tr_st [16], tr_re [16], tr_we [16], tr_iv [16], tr_dd [16], tr3_re [16], tr3_iv [16];
  logic [15:0] tr_addr [16], tr_wd [16], tr_ird [16], tr_drd [16], tr3_ird [16];

  always #5 clock = ~clock;

  pmips_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u_dut (
    .clock(clock), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_valid(i_valid), .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .stall(stall), .grant(grant));

  pmips_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3),
    .i_valid(i_valid3), .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata3), .d_done(d_done3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_re(mem_re3), .mem_we(mem_we3), .mem_rdata(mem_rdata3), .stall(stall3), .grant(grant3));

  // Memory models: data is presented only in the single cycle RD_LAT after the strobe.
  assign mem_rdata  = (m1_cnt == 3'd1) ? sim_mem1[m1_a] : 16'hDEAD;
  assign mem_rdata3 = (m3_cnt == 3'd1) ? sim_mem3[m3_a] : 16'hDEAD;
  always @(posedge clock) begin
    if (mem_we) sim_mem1[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) begin m1_cnt <= 3'd1; m1_a <= mem_addr[7:0]; end
    else if (m1_cnt != 0) m1_cnt <= m1_cnt - 3'd1;
    if (mem_we3) sim_mem3[mem_addr3[7:0]] <= mem_wdata3;
    if (mem_re3) begin m3_cnt <= 3'd3; m3_a <= mem_addr3[7:0]; end
    else if (m3_cnt != 0) m3_cnt <= m3_cnt - 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic f, input logic [15:0] ia, input logic rd, input logic wr,
                       input logic [15:0] da, input logic [15:0] wd);
    i_req = f; i_addr = ia; d_read = rd; d_write = wr; d_addr = da; d_wdata = wd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1;
    tick();
    #1;
    chk("reset_outputs", {14'd0, grant, stall, mem_re, mem_we, i_valid, d_done, i_rdata, d_rdata},
        32'd0);
    reset = 0;
  endtask

  task automatic trace(input int s, input int n);
    for (int k = s; k < s + n; k++) begin
      #1;
      tr_st[k] = stall; tr_re[k] = mem_re; tr_we[k] = mem_we; tr_iv[k] = i_valid;
      tr_dd[k] = d_done; tr_addr[k] = mem_addr; tr_wd[k] = mem_wdata; tr_ird[k] = i_rdata;
      tr_drd[k] = d_rdata; tr3_re[k] = mem_re3; tr3_iv[k] = i_valid3; tr3_ird[k] = i_rdata3;
      tick();
    end
  endtask

  function automatic logic [15:0] pk(input logic b [16], input int n);
    logic [15:0] r = 0;
    for (int k = 0; k < n; k++) r[k] = b[k];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      sim_mem1[i] = 16'($urandom);
      sim_mem3[i] = sim_mem1[i];
    end
    sim_mem1[8'h00] = 16'h2345; sim_mem1[8'h80] = 16'h00AA;
    sim_mem1[8'h10] = 16'h1010; sim_mem1[8'h04] = 16'h4444;
    sim_mem3[8'h04] = 16'h0C0D;
    for (int i = 0; i < 256; i++) ref_mem[i] = sim_mem1[i];
    tick();
    // fetch only
    do_reset();
    drive(1, 16'h0000, 0, 0, 0, 0);
    trace(0, 8);
    chk("t1_re_pattern", pk(tr_re, 8), 16'h0022);
    chk("t1_addr_c1", tr_addr[1], 16'h0000);
    chk("t1_valid_pattern", pk(tr_iv, 8), 16'h0088);
    chk("t1_rdata_c3", tr_ird[3], 16'h2345);
    chk("t1_stall_c0_3", pk(tr_st, 4), 16'h0007);
    // fetch and load together: data wins
    do_reset();
    drive(1, 16'h0010, 1, 0, 16'h0080, 0);
    trace(0, 7);
    chk("t2_re_pattern", pk(tr_re, 7), 16'h0012);
    chk("t2_addr_c1", tr_addr[1], 16'h0080);
    chk("t2_addr_c4", tr_addr[4], 16'h0010);
    chk("t2_done_pattern", pk(tr_dd, 7), 16'h0008);
    chk("t2_drdata_c3", tr_drd[3], 16'h00AA);
    chk("t2_valid_pattern", pk(tr_iv, 7), 16'h0040);
    chk("t2_irdata_c6", tr_ird[6], 16'h1010);
    chk("t2_stall", pk(tr_st, 7), 16'h003F);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    // reset during D_RD discards the load
    drive(0, 0, 1, 0, 16'h0081, 0);
    trace(0, 2);
    reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    #1;
    chk("t5_after_reset", {grant, stall, mem_re, mem_we, d_rdata}, 21'd0);
    reset = 0;
    trace(0, 6);
    chk("t5_no_done", pk(tr_dd, 6), 16'h0000);
    // store
    do_reset();
    drive(0, 0, 0, 1, 16'h0040, 16'hBEEF);
    trace(0, 3);
    ref_mem[8'h40] = 16'hBEEF;
    chk("t3_we_pattern", pk(tr_we, 3), 16'h0002);
    chk("t3_addr_wdata_c1", {tr_addr[1], tr_wd[1]}, 32'h0040BEEF);
    chk("t3_done_pattern", pk(tr_dd, 3), 16'h0004);
    chk("t3_no_re", pk(tr_re, 3), 16'h0000);
    chk("t3_stall", pk(tr_st, 3), 16'h0003);
    // load arrives while fetch is in flight; fetch must not be reissued
    do_reset();
    drive(1, 16'h0004, 0, 0, 0, 0);
    trace(0, 1);
    drive(1, 16'h0004, 1, 0, 16'h0080, 0);
    trace(1, 8);
    chk("t6_re_pattern", pk(tr_re, 9), 16'h0112);
    chk("t6_addr_c4", tr_addr[4], 16'h0080);
    chk("t6_addr_c8", tr_addr[8], 16'h0080);
    chk("t6_valid_pattern", pk(tr_iv, 9), 16'h0008);
    chk("t6_done_pattern", pk(tr_dd, 9), 16'h0040);
    chk("t6_stall", pk(tr_st, 8), 16'h00BF);
    drive(0, 0, 0, 0, 0, 0);
    // RD_LAT=3 fetch
    do_reset();
    drive(1, 16'h0004, 0, 0, 0, 0);
    trace(0, 12);
    chk("t4_re_pattern", pk(tr3_re, 12), 16'h0082);
    chk("t4_valid_pattern", pk(tr3_iv, 12), 16'h0820);
    chk("t4_rdata_c5", tr3_ird[5], 16'h0C0D);
    // randomized pipeline cycles on the RD_LAT=1 instance
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int op, n, re, we, iv, dd, exp_n;
      logic f, ld, st, fin;
      logic [15:0] ia, da, wd;
      op = int'($urandom_range(0, 5));
      f = (op == 1) || (op == 4) || (op == 5);
      ld = (op == 2) || (op == 4);
      st = (op == 3) || (op == 5);
      ia = 16'($urandom); da = 16'($urandom); wd = 16'($urandom);
      drive(f, ia, ld, st, da, wd);
      exp_n = (f ? 3 : 0) + (ld ? 3 : 0) + (st ? 2 : 0);
      n = 0; re = 0; we = 0; iv = 0; dd = 0; fin = 0;
      for (int k = 0; k < 40 && !fin; k++) begin
        #1;
        if (mem_re) begin
          chk("rnd_re_addr", mem_addr, (ld && re == 0) ? da : ia);
          re++;
        end
        if (mem_we) begin
          chk("rnd_we_addr_data", {mem_addr, mem_wdata}, {da, wd});
          we++;
        end
        iv += int'(i_valid);
        dd += int'(d_done);
        if (!stall) fin = 1;
        else n++;
        tick();
      end
      chk("rnd_finished", fin, 1);
      chk("rnd_stall_cycles", n, exp_n);
      chk("rnd_re_count", re, int'(f) + int'(ld));
      chk("rnd_we_count", we, int'(st));
      chk("rnd_valid_count", iv, int'(f));
      chk("rnd_done_count", dd, int'(ld | st));
      if (st) ref_mem[da[7:0]] = wd;
      if (ld) chk("rnd_d_rdata", d_rdata, ref_mem[da[7:0]]);
      if (f) chk("rnd_i_rdata", i_rdata, ref_mem[ia[7:0]]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pmips_mem_arbiter.md
Name: pmips_mem_arbiter

Overview:
- Shares one single-ported synchronous memory (Spartan-3E BRAM or external SRAM) between the PMIPS instruction-fetch port and the MEM-stage data port.
- Sequences each access with a small FSM, with data taking priority over fetch.
- Returns read data to the correct requester and drives a global pipeline stall until every access of the current pipeline cycle is complete.

Parameters:
- AW, 16: address width.
- DW, 16: data width.
- RD_LAT, 1: cycles from the mem_re cycle to the cycle mem_rdata is valid (legal range 1-7).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- i_req  in  1  fetch request; held high by the IF stage.
- i_addr  in  AW  fetch address (PC).
- i_rdata  out  DW  fetched instruction; holds its value until the next fetch completes.
- i_valid  out  1  one-cycle pulse: i_rdata updated.
- d_read  in  1  load request from EX/MEM.
- d_write  in  1  store request; d_read and d_write are never high together.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load result; holds its value until the next load completes.
- d_done  out  1  one-cycle pulse: load or store complete.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_re  out  1  memory read strobe, exactly one cycle per read.
- mem_we  out  1  memory write strobe, exactly one cycle per write.
- mem_rdata  in  DW  memory read data.
- stall  out  1  hold PC, IF/ID and ID/EX; the pipeline advances only in cycles where stall=0.
- grant  out  2  debug: 00 idle, 01 fetch, 10 data read, 11 data write.

Behaviour:
- Reset: state IDLE, wait counter 0, i_hold=d_hold=0. All outputs are 0 from the first cycle after the reset edge. An in-flight read is discarded and produces no valid/done pulse.
- States: IDLE, I_RD, D_RD, D_WR.
- Completion flags:
  - i_hold is set when i_valid pulses; d_hold is set when d_done pulses.
  - Both are cleared at the edge ending any cycle with stall=0.
- Pending terms:
  - ipend = i_req & ~i_hold & ~i_valid
  - dpend = (d_read|d_write) & ~d_hold & ~d_done
- IDLE grant:
  - dpend: go to D_RD or D_WR.
  - Otherwise ipend: go to I_RD.
  - Otherwise stay in IDLE.
  - The address (and write data for a store) is registered into mem_addr/mem_wdata at the grant edge.
- Read states (I_RD, D_RD):
  - mem_re=1 only in the first cycle of the state.
  - The counter counts RD_LAT cycles; mem_rdata is captured into i_rdata or d_rdata at the end of cycle (first+RD_LAT).
  - The next cycle is IDLE with i_valid or d_done = 1.
  - Request-to-valid latency is RD_LAT+2 cycles.
- D_WR:
  - mem_we=1 for one cycle.
  - The next cycle is IDLE with d_done=1.
  - mem_re is never asserted for a store.
- Completion cycle: the completing port is not regranted (its pend term is 0), but the other port may be granted in that same cycle.
- Stall: stall = (i_req & ~i_hold & ~i_valid) | ((d_read|d_write) & ~d_hold & ~d_done). A 0 means every requested access of this pipeline cycle is done.
- Fetch throughput with no data traffic: one instruction per RD_LAT+3 cycles.
- mem_addr/mem_wdata keep their last values when idle; mem_re and mem_we are 0 outside their strobe cycle.
- Request inputs are sampled only in IDLE. Changes during a busy state are ignored until IDLE.

Test Plan:
1. Reset, then i_req=1, i_addr=0x0000, memory returns 0x2345 (RD_LAT=1):
   - mem_re in cycle 1 with mem_addr=0x0000.
   - i_valid=1 and i_rdata=0x2345 in cycle 3.
   - stall=1 in cycles 0-2 and 0 in cycle 3.
   - With continuous advance, the next fetch's i_valid arrives in cycle 7.
2. Simultaneous i_req (0x0010) and d_read (0x0080 -> 0x00AA):
   - Data is granted first: mem_re at 0x0080 in cycle 1, d_done with d_rdata=0x00AA in cycle 3.
   - Fetch mem_re at 0x0010 in cycle 4, i_valid in cycle 6.
   - stall is high in cycles 0-5 and low in cycle 6.
3. Store d_write, d_addr=0x0040, d_wdata=0xBEEF, i_req=0:
   - mem_we=1 in cycle 1 with mem_addr=0x0040 and mem_wdata=0xBEEF.
   - d_done in cycle 2; mem_re is never 1.
   - stall is high in cycles 0-1 and low in cycle 2.
4. RD_LAT=3, fetch from 0x0004:
   - mem_re in cycle 1, data sampled in cycle 4, i_valid in cycle 5.
   - Period is 6 cycles under continuous fetch.
5. Reset asserted during D_RD (cycle 2):
   - Next cycle: grant=00, stall=0, mem_re=0, mem_we=0, d_rdata=0.
   - No d_done ever fires for the aborted load.
6. Fetch completes (i_hold=1) while a load is still pending with the pipeline held:
   - No second mem_re occurs for the fetch.
   - stall drops only in the load's d_done cycle, and both holds clear at that edge.
